hazard_unit: RTL and testbench
==============================

# hazard_unit

Scoreboard-based stall and forwarding controller for the five-stage pipeline. It consumes the per-instruction Tuse/Tnew and register-address information that the decode-stage control unit produces. It tracks the in-flight writers in the E, M and W slots, asserts a decode stall when a source operand cannot be supplied in time, and drives forwarding-mux selects for the D and E stage operands.

## Interface
- No parameters; register addresses are 5 bits and Tuse/Tnew are 2 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all slots.
- d_rs  in  5  rs field of the instruction in D.
- d_rt  in  5  rt field of the instruction in D.
- d_tuse_rs  in  2  cycles after D until rs is needed.
  - 0 = needed in D (branch/jr compare).
  - 1 = needed in E.
  - 2 = needed in M (store data).
  - 3 = operand unused.
- d_tuse_rt  in  2  same encoding for rt.
- d_wen  in  1  the D instruction writes the register file.
- d_wdst  in  5  destination register of the D instruction (rt, rd or 31, already resolved).
- d_tnew  in  2  Tnew the instruction will carry on entering E.
  - ALU = 1, load = 2, lui/jal = 0.
- stall  out  1  freeze PC and F/D; insert a bubble into D/E.
- fwd_d_rs  out  2  D-operand source select. 0 = register file, 1 = E slot, 2 = M slot, 3 = W slot.
- fwd_d_rt  out  2  same encoding as fwd_d_rs.
- fwd_e_rs  out  2  E-operand source select. 0 = D/E register value, 2 = M slot, 3 = W slot; 1 is never driven.
- fwd_e_rt  out  2  same encoding as fwd_e_rs.

## Operation
- **Slot state.** Three slots: E, M and W. Each slot holds wen, dst[4:0] and tnew[1:0]. The E slot also holds rs, rt, tuse_rs and tuse_rt.
- **A slot matches register s when** slot.wen = 1, slot.dst = s, and s ≠ 0.
- **Stall condition.** For each D source s ∈ {rs, rt} with tuse ≠ 3:
  - find the youngest matching slot among E, then M;
  - stall when that slot's tnew > tuse.
  - stall = OR over both sources.
  - The W slot never stalls (its tnew is always 0).
- **D forwarding.** For each source, take the youngest matching slot among E, M, W.
  - If that slot's tnew = 0, select it.
  - Otherwise select 0.
  - No match selects 0.
  - Older slots are never used when a younger slot matches.
- **E forwarding.** Same rule, applied to the E slot's rs/rt over the M and W slots only.
- **Slot update each clock:**
  - **reset:** all fields of all slots = 0.
  - **stall = 1:**
    - E ← bubble (wen = 0, dst = 0, tnew = 0, rs = rt = 0, tuse = 3).
    - M ← E and W ← M, with the decrement below.
  - **stall = 0:** E ← D inputs (tnew = d_tnew); M ← E; W ← M.
  - **Decrement:** tnew on transfer is max(tnew − 1, 0), a saturating decrement.
- Reset has priority over stall. D inputs are ignored during reset.

## Timing
- stall and all fwd_* outputs are purely combinational from the current slot state and the D inputs; there is zero-cycle latency.
- **Reset values:** with all slots cleared, stall = 0 and all fwd_* = 0 in the cycle after reset, given any D inputs.
- A load followed by a dependent instruction with Tuse 1 produces exactly one stall cycle.
- A load followed by a dependent branch with Tuse 0 produces exactly two stall cycles.
- An ALU result followed by a dependent branch produces exactly one stall cycle.
- While stalled, D inputs are held upstream. The unit re-evaluates each cycle and needs no internal stall memory.
- If reset is asserted mid-stall, stall is 0 in the cycle after reset.

## Test plan
- **Reset:** assert reset 2 cycles with d_rs = 8 and d_wen = 1, then release.
  - Required: stall = 0 and all fwd_* = 0 on the first cycle after release.
- **Load-use, E operand:**
  - Stimulus:
    - cycle 0: D = lw, d_wdst = 8, d_tnew = 2.
    - cycle 1: D = add, d_rs = 8, d_tuse_rs = 1.
  - Required:
    - cycle 1: stall = 1.
    - cycle 2: stall = 0.
    - cycle 3: fwd_e_rs = 3.
- **ALU → beq, D operand:**
  - Stimulus: add with d_wdst = 9 and d_tnew = 1, then beq with d_rs = 9 and d_tuse_rs = 0.
  - Required:
    - first cycle: stall = 1, fwd_d_rs = 0.
    - next cycle: stall = 0, fwd_d_rs = 2.
- **$0 immunity:** writer with d_wdst = 0 and d_tnew = 2, followed by a reader with d_rs = 0 and d_tuse_rs = 0.
  - Required: stall = 0 and fwd_d_rs = 0 throughout.
- **Youngest-writer priority:** two consecutive ALU writers to $5 (d_tnew = 1), then a reader with d_rt = 5 and d_tuse_rt = 1.
  - Required: no stall. One cycle later, the reader in E has fwd_e_rt = 2, selecting the second writer.
  - Check that the older writer is never selected.
- **Reset mid-stall:** lw $8, then beq on $8 (stall = 1); assert reset on the first stall cycle.
  - Required: stall = 0 the following cycle and all slots cleared.

Source files
------------

// File: rtl/hazard_unit.sv
// Stall and forwarding controller for the five-stage pipeline: tracks the writers
// in the E, M and W slots and compares their Tnew against the D instruction's Tuse.
module hazard_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_wen,
  input  logic [4:0] d_wdst,
  input  logic [1:0] d_tnew,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt
);

  logic       e_wen_q, e_wen_d;
  logic [4:0] e_dst_q, e_dst_d;
  logic [1:0] e_tnew_q, e_tnew_d;
  logic [4:0] e_rs_q, e_rs_d;
  logic [4:0] e_rt_q, e_rt_d;
  logic       m_wen_q, m_wen_d;
  logic [4:0] m_dst_q, m_dst_d;
  logic [1:0] m_tnew_q, m_tnew_d;
  logic       w_wen_q, w_wen_d;
  logic [4:0] w_dst_q, w_dst_d;
  logic [1:0] w_tnew_q, w_tnew_d;

  function automatic logic slot_match(input logic wen, input logic [4:0] dst,
                                      input logic [4:0] s);
    return wen && (dst == s) && (s != 5'd0);
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Only the youngest matching writer decides; W always has Tnew 0 so it never stalls.
  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse);
    if (tuse == 2'd3) return 1'b0;
    if (slot_match(e_wen_q, e_dst_q, s)) return e_tnew_q > tuse;
    if (slot_match(m_wen_q, m_dst_q, s)) return m_tnew_q > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] src_fwd_d(input logic [4:0] s);
    if (slot_match(e_wen_q, e_dst_q, s)) return (e_tnew_q == 2'd0) ? 2'd1 : 2'd0;
    if (slot_match(m_wen_q, m_dst_q, s)) return (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
    if (slot_match(w_wen_q, w_dst_q, s)) return (w_tnew_q == 2'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] src_fwd_e(input logic [4:0] s);
    if (slot_match(m_wen_q, m_dst_q, s)) return (m_tnew_q == 2'd0) ? 2'd2 : 2'd0;
    if (slot_match(w_wen_q, w_dst_q, s)) return (w_tnew_q == 2'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  always_comb begin
    stall    = src_stall(d_rs, d_tuse_rs) | src_stall(d_rt, d_tuse_rt);
    fwd_d_rs = src_fwd_d(d_rs);
    fwd_d_rt = src_fwd_d(d_rt);
    fwd_e_rs = src_fwd_e(e_rs_q);
    fwd_e_rt = src_fwd_e(e_rt_q);
  end

  // A stall turns the D instruction into a bubble in E while older slots keep moving.
  always_comb begin
    e_wen_d  = d_wen;
    e_dst_d  = d_wdst;
    e_tnew_d = d_tnew;
    e_rs_d   = d_rs;
    e_rt_d   = d_rt;
    if (stall) begin
      e_wen_d  = 1'b0;
      e_dst_d  = 5'd0;
      e_tnew_d = 2'd0;
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
    end
    m_wen_d  = e_wen_q;
    m_dst_d  = e_dst_q;
    m_tnew_d = sat_dec(e_tnew_q);
    w_wen_d  = m_wen_q;
    w_dst_d  = m_dst_q;
    w_tnew_d = sat_dec(m_tnew_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_wen_q  <= 1'b0;
      e_dst_q  <= 5'd0;
      e_tnew_q <= 2'd0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      m_wen_q  <= 1'b0;
      m_dst_q  <= 5'd0;
      m_tnew_q <= 2'd0;
      w_wen_q  <= 1'b0;
      w_dst_q  <= 5'd0;
      w_tnew_q <= 2'd0;
    end else begin
      e_wen_q  <= e_wen_d;
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_wen_q  <= m_wen_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_wen_q  <= w_wen_d;
      w_dst_q  <= w_dst_d;
      w_tnew_q <= w_tnew_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus random instruction streams
// checked against a model that tracks each writer by the absolute cycle its result is ready.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wdst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wen;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int checks = 0;
  int failures = 0;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wen(d_wen), .d_wdst(d_wdst), .d_tnew(d_tnew),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
  );

  always #5 clk = ~clk;

  // In-flight instructions, youngest first (E, M, W); ready = cycle its value exists.
  typedef struct {
    logic       wen;
    logic [4:0] dst;
    int         ready;
    logic [4:0] rs;
    logic [4:0] rt;
  } instr_t;

  instr_t pipe [3];
  int now = 0;

  function automatic int avail(int i);
    int a;
    a = pipe[i].ready - now;
    return (a > 0) ? a : 0;
  endfunction

  function automatic logic writes(int i, logic [4:0] s);
    return pipe[i].wen && (pipe[i].dst == s) && (s != 5'd0);
  endfunction

  function automatic logic exp_src_stall(logic [4:0] s, logic [1:0] tuse);
    if (tuse == 2'd3) return 1'b0;
    for (int i = 0; i < 2; i++)
      if (writes(i, s)) return avail(i) > int'(tuse);
    return 1'b0;
  endfunction

  function automatic logic exp_stall();
    return exp_src_stall(d_rs, d_tuse_rs) || exp_src_stall(d_rt, d_tuse_rt);
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] s, int first);
    for (int i = first; i < 3; i++)
      if (writes(i, s)) return (avail(i) == 0) ? 2'(i + 1) : 2'd0;
    return 2'd0;
  endfunction

  task automatic tick();
    logic st;
    st = exp_stall();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        pipe[i].wen = 1'b0; pipe[i].dst = 5'd0; pipe[i].ready = 0;
        pipe[i].rs = 5'd0; pipe[i].rt = 5'd0;
      end
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st) begin
        pipe[0].wen = 1'b0; pipe[0].dst = 5'd0; pipe[0].ready = 0;
        pipe[0].rs = 5'd0; pipe[0].rt = 5'd0;
      end else begin
        pipe[0].wen = d_wen; pipe[0].dst = d_wdst; pipe[0].ready = now + 1 + int'(d_tnew);
        pipe[0].rs = d_rs; pipe[0].rt = d_rt;
      end
    end
    now++;
    #1;
  endtask

  task automatic drive(logic [4:0] rs, logic [1:0] trs, logic [4:0] rt, logic [1:0] trt,
                       logic wen, logic [4:0] dst, logic [1:0] tnew);
    d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
    d_wen = wen; d_wdst = dst; d_tnew = tnew;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd8, 2'd0, 5'd8, 2'd0, 1'b1, 5'd8, 2'd2);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    checks++;
    if (fwd_d_rs !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwd_d_rs: got %0d want 0", fwd_d_rs); end
    checks++;
    if (fwd_d_rt !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwd_d_rt: got %0d want 0", fwd_d_rt); end
    checks++;
    if (fwd_e_rs !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwd_e_rs: got %0d want 0", fwd_e_rs); end
    checks++;
    if (fwd_e_rt !== 2'd0) begin failures++; $display("[TB] FAIL reset_fwd_e_rt: got %0d want 0", fwd_e_rt); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(5'd29, 2'd1, 5'd0, 2'd3, 1'b1, 5'd8, 2'd2);
    tick();
    drive(5'd8, 2'd1, 5'd10, 2'd1, 1'b1, 5'd11, 2'd1);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("[TB] FAIL load_use_stall_c1: got %b want 1", stall); end
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL load_use_stall_c2: got %b want 0", stall); end
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    checks++;
    if (fwd_e_rs !== 2'd3) begin failures++; $display("[TB] FAIL load_use_fwd_e_rs: got %0d want 3", fwd_e_rs); end
    checks++;
    if (fwd_e_rt !== 2'd0) begin failures++; $display("[TB] FAIL load_use_fwd_e_rt: got %0d want 0", fwd_e_rt); end
  endtask

  task automatic test_alu_branch();
    do_reset();
    drive(5'd1, 2'd1, 5'd2, 2'd1, 1'b1, 5'd9, 2'd1);
    tick();
    drive(5'd9, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("[TB] FAIL alu_beq_stall_c1: got %b want 1", stall); end
    checks++;
    if (fwd_d_rs !== 2'd0) begin failures++; $display("[TB] FAIL alu_beq_fwd_c1: got %0d want 0", fwd_d_rs); end
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL alu_beq_stall_c2: got %b want 0", stall); end
    checks++;
    if (fwd_d_rs !== 2'd2) begin failures++; $display("[TB] FAIL alu_beq_fwd_c2: got %0d want 2", fwd_d_rs); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(5'd1, 2'd1, 5'd0, 2'd3, 1'b1, 5'd0, 2'd2);
    tick();
    drive(5'd0, 2'd0, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (stall !== 1'b0) begin failures++; $display("[TB] FAIL zero_reg_stall c%0d: got %b want 0", c, stall); end
      checks++;
      if (fwd_d_rs !== 2'd0) begin failures++; $display("[TB] FAIL zero_reg_fwd c%0d: got %0d want 0", c, fwd_d_rs); end
      tick();
    end
  endtask

  task automatic test_youngest_writer();
    do_reset();
    drive(5'd1, 2'd1, 5'd0, 2'd3, 1'b1, 5'd5, 2'd1);
    tick();
    drive(5'd2, 2'd1, 5'd0, 2'd3, 1'b1, 5'd5, 2'd1);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL youngest_stall_w2: got %b want 0", stall); end
    tick();
    drive(5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL youngest_stall_rd: got %b want 0", stall); end
    checks++;
    if (fwd_d_rt !== 2'd0) begin failures++; $display("[TB] FAIL youngest_fwd_d_rt: got %0d want 0", fwd_d_rt); end
    tick();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0);
    checks++;
    if (fwd_e_rt !== 2'd2) begin failures++; $display("[TB] FAIL youngest_fwd_e_rt: got %0d want 2", fwd_e_rt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(5'd29, 2'd1, 5'd0, 2'd3, 1'b1, 5'd8, 2'd2);
    tick();
    drive(5'd8, 2'd0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("[TB] FAIL midstall_pre: got %b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("[TB] FAIL midstall_post: got %b want 0", stall); end
    checks++;
    if (fwd_d_rs !== 2'd0) begin failures++; $display("[TB] FAIL midstall_fwd_d_rs: got %0d want 0", fwd_d_rs); end
    tick();
    checks++;
    if (stall !== 1'b0 || fwd_d_rs !== 2'd0) begin
      failures++; $display("[TB] FAIL midstall_cleared: stall=%b fwd_d_rs=%0d want 0/0", stall, fwd_d_rs);
    end
  endtask

  task automatic test_random();
    logic       e_st;
    logic [1:0] e_fdrs, e_fdrt, e_fers, e_fert;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      // A stalled D instruction is held upstream until it issues.
      if (!exp_stall() || reset)
        drive(5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      else
        #1;
      e_st   = exp_stall();
      e_fdrs = exp_fwd(d_rs, 0);
      e_fdrt = exp_fwd(d_rt, 0);
      e_fers = exp_fwd(pipe[0].rs, 1);
      e_fert = exp_fwd(pipe[0].rt, 1);
      checks++;
      if (stall !== e_st) begin failures++; $display("[TB] FAIL rand_stall c%0d: got %b want %b", c, stall, e_st); end
      checks++;
      if (fwd_d_rs !== e_fdrs) begin failures++; $display("[TB] FAIL rand_fwd_d_rs c%0d: got %0d want %0d", c, fwd_d_rs, e_fdrs); end
      checks++;
      if (fwd_d_rt !== e_fdrt) begin failures++; $display("[TB] FAIL rand_fwd_d_rt c%0d: got %0d want %0d", c, fwd_d_rt, e_fdrt); end
      checks++;
      if (fwd_e_rs !== e_fers) begin failures++; $display("[TB] FAIL rand_fwd_e_rs c%0d: got %0d want %0d", c, fwd_e_rs, e_fers); end
      checks++;
      if (fwd_e_rt !== e_fert) begin failures++; $display("[TB] FAIL rand_fwd_e_rt c%0d: got %0d want %0d", c, fwd_e_rt, e_fert); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_wen = 1'b0; d_wdst = 5'd0; d_tnew = 2'd0;
    for (int i = 0; i < 3; i++) begin
      pipe[i].wen = 1'b0; pipe[i].dst = 5'd0; pipe[i].ready = 0;
      pipe[i].rs = 5'd0; pipe[i].rt = 5'd0;
    end
    @(negedge clk);
    test_reset();
    test_load_use();
    test_alu_branch();
    test_zero_reg();
    test_youngest_writer();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
